// File: rtl/ultrascan_report_pkg.sv
// Shared types for the report collection path: record layout,
// drop counter width and the capture FSM states.
package ultrascan_report_pkg;

  localparam int DROP_CNT_W   = 16;
  localparam int DEF_OFFSET_W = 32;
  localparam int DEF_ID_W     = 3;

  typedef struct packed {
    logic [DEF_OFFSET_W-1:0] offset;
    logic [DEF_ID_W-1:0]     id;
  } report_rec_t;

  typedef enum logic {
    IDLE,
    DRAIN
  } fsm_t;

endpackage

// File: rtl/report_fifo.sv
// Show-ahead record FIFO; a push into a full FIFO is legal when
// a pop happens in the same cycle (the freed slot is reused).
import ultrascan_report_pkg::*;

module report_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = report_rec_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/report_collector.sv
// Turns per-symbol automata report vectors into {offset, id}
// records, lowest id first, with stall back-pressure to the feeder.
import ultrascan_report_pkg::*;

module report_collector #(
  parameter int  NUM_REPORTS = 8,
  parameter int  OFFSET_W    = 32,
  parameter int  FIFO_DEPTH  = 16,
  parameter int  REPORT_LAT  = 1,
  localparam int ID_W = (NUM_REPORTS > 1) ? $clog2(NUM_REPORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   flush,
  input  logic [NUM_REPORTS-1:0] report_vec,
  output logic                   stall,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OFFSET_W-1:0]    out_offset,
  output logic [ID_W-1:0]        out_id,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
    logic [ID_W-1:0]     id;
  } rec_t;

  fsm_t                   state;
  fsm_t                   state_nx;
  logic [OFFSET_W-1:0]    sym_count;
  logic [OFFSET_W-1:0]    pend_off;
  logic [NUM_REPORTS-1:0] pending;
  logic [NUM_REPORTS-1:0] pend_rest;
  logic [ID_W-1:0]        low_id;
  logic                   hit;
  logic                   multi;
  logic                   can_push;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CW-1:0]          fifo_count;
  logic                   accept;
  logic                   drop;
  rec_t                   wrec;
  rec_t                   head;

  assign pend_rest = pending & (pending - NUM_REPORTS'(1));
  assign multi     = |pend_rest;
  assign hit       = run & (|report_vec);
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign can_push  = ~fifo_full | fifo_pop;
  assign wrec      = '{offset: pend_off, id: low_id};

  assign stall      = multi | (fifo_count >= CW'(FIFO_DEPTH - 1));
  assign out_valid  = ~fifo_empty;
  assign out_offset = fifo_empty ? '0 : head.offset;
  assign out_id     = fifo_empty ? '0 : head.id;

  always_comb begin
    low_id = '0;
    for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
      if (pending[i]) low_id = ID_W'(i);
    end
  end

  // A new vector is only taken when pending empties this cycle.
  always_comb begin
    state_nx  = state;
    fifo_push = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          accept   = 1'b1;
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        fifo_push = can_push;
        if (hit) begin
          if (!multi && can_push) accept = 1'b1;
          else                    drop   = 1'b1;
        end
        if (fifo_push && !multi && !accept) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count  <= '0;
      pending    <= '0;
      pend_off   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      sym_count  <= '0;
      pending    <= '0;
      pend_off   <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (run) sym_count <= sym_count + OFFSET_W'(1);
      if (accept) begin
        pending  <= report_vec;
        pend_off <= sym_count - OFFSET_W'(REPORT_LAT);
      end else if (fifo_push) begin
        pending  <= pend_rest;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
      end
    end
  end

  report_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .wdata (wrec),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_report_collector.sv
// Scoreboard bench for report_collector: a 32-bit offset instance
// for the main scenarios and a 4-bit offset instance for wrap.
module tb_report_collector;

  typedef struct {
    logic [31:0] off;
    logic [2:0]  id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  report_vec = '0;
  logic        out_ready = 1'b1;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_offset;
  logic [2:0]  out_id;
  logic        overflow;
  logic [15:0] drop_count;

  logic        run2 = 1'b0;
  logic [7:0]  vec2 = '0;
  logic        stall2;
  logic        valid2;
  logic [3:0]  off2;
  logic [2:0]  id2;
  logic        ovf2;
  logic [15:0] drops2;

  int total = 0;
  int bad = 0;
  logic [31:0] sc = '0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  report_collector #(
    .NUM_REPORTS (8),
    .OFFSET_W    (32),
    .FIFO_DEPTH  (16),
    .REPORT_LAT  (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .flush      (flush),
    .report_vec (report_vec),
    .stall      (stall),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_offset (out_offset),
    .out_id     (out_id),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  report_collector #(
    .NUM_REPORTS (8),
    .OFFSET_W    (4),
    .FIFO_DEPTH  (16),
    .REPORT_LAT  (1)
  ) dut_w (
    .clk        (clk),
    .reset      (reset),
    .run        (run2),
    .flush      (1'b0),
    .report_vec (vec2),
    .stall      (stall2),
    .out_valid  (valid2),
    .out_ready  (1'b1),
    .out_offset (off2),
    .out_id     (id2),
    .overflow   (ovf2),
    .drop_count (drops2)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [7:0] v);
    run = r;
    report_vec = v;
    @(posedge clk);
    #1;
    if (r) sc = sc + 32'd1;
  endtask

  task automatic cyc2(input logic r, input logic [7:0] v);
    run2 = r;
    vec2 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_cyc();
    run = 1'b0;
    report_vec = '0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    sc = '0;
  endtask

  task automatic drain1(input string name);
    for (int c = 0; c < 100 && (q1.size() != 0 || out_valid); c++)
      cyc(1'b0, 8'h00);
    chk(name, 64'(q1.size()), 64'd0);
  endtask

  task automatic drain2(input string name);
    run2 = 1'b0;
    vec2 = '0;
    for (int c = 0; c < 100 && (q2.size() != 0 || valid2); c++)
      cyc2(1'b0, 8'h00);
    chk(name, 64'(q2.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rec: got off=%0h id=%0d required none",
                 out_offset, out_id);
      end else begin
        e = q1.pop_front();
        chk("rec_off", 64'(out_offset), 64'(e.off));
        chk("rec_id", 64'(out_id), 64'(e.id));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rec_w: got off=%0h id=%0d required none",
                 off2, id2);
      end else begin
        e = q2.pop_front();
        chk("wrap_off", 64'(off2), 64'(e.off));
        chk("wrap_id", 64'(id2), 64'(e.id));
      end
    end
  end

  initial begin
    int sent;
    int stalled;
    bit released;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drops", 64'(drop_count), 64'd0);
    chk("rst_off", 64'(out_offset), 64'd0);
    chk("rst_id", 64'(out_id), 64'd0);

    // single hit at sym_count 10
    repeat (10) cyc(1'b1, 8'h00);
    q1.push_back('{32'd9, 3'd2});
    cyc(1'b1, 8'h04);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    cyc(1'b0, 8'h00);
    chk("lat_valid", 64'(out_valid), 64'd1);
    drain1("single_drain");
    chk("single_ovf", 64'(overflow), 64'd0);

    // multi-bit vector at sym_count 5
    flush_cyc();
    repeat (5) cyc(1'b1, 8'h00);
    q1.push_back('{32'd4, 3'd0});
    q1.push_back('{32'd4, 3'd4});
    q1.push_back('{32'd4, 3'd7});
    cyc(1'b1, 8'h91);
    chk("multi_stall3", 64'(stall), 64'd1);
    cyc(1'b0, 8'h00);
    chk("multi_stall2", 64'(stall), 64'd1);
    cyc(1'b0, 8'h00);
    chk("multi_stall1", 64'(stall), 64'd0);
    drain1("multi_drain");

    // drop: second vector while two bits pending
    q1.push_back('{32'd5, 3'd0});
    q1.push_back('{32'd5, 3'd1});
    cyc(1'b1, 8'h03);
    cyc(1'b1, 8'h01);
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_cnt", 64'(drop_count), 64'd1);
    drain1("drop_drain");

    // backpressure with stall honoured
    flush_cyc();
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_drops", 64'(drop_count), 64'd0);
    out_ready = 1'b0;
    sent = 0;
    stalled = 0;
    released = 0;
    for (int c = 0; c < 300 && sent < 20; c++) begin
      if (stall) begin
        cyc(1'b0, 8'h00);
        stalled++;
        if (stalled >= 5 && !released) begin
          chk("bp_full_valid", 64'(out_valid), 64'd1);
          chk("bp_sent_at_full", 64'(sent), 64'd16);
          chk("bp_no_drop", 64'(drop_count), 64'd0);
          out_ready = 1'b1;
          released = 1;
        end
      end else begin
        q1.push_back('{sc - 32'd1, 3'(sent % 8)});
        cyc(1'b1, 8'h01 << (sent % 8));
        sent++;
      end
    end
    chk("bp_sent", 64'(sent), 64'd20);
    drain1("bp_drain");
    chk("bp_drops_end", 64'(drop_count), 64'd0);

    // 4-bit offset wrap
    q2.push_back('{32'd15, 3'd1});
    cyc2(1'b1, 8'h02);
    repeat (14) cyc2(1'b1, 8'h00);
    q2.push_back('{32'd14, 3'd3});
    cyc2(1'b1, 8'h08);
    q2.push_back('{32'd15, 3'd0});
    cyc2(1'b1, 8'h01);
    drain2("wrap_drain");
    chk("wrap_drops", 64'(drops2), 64'd0);

    // async reset mid-drain
    flush_cyc();
    out_ready = 1'b0;
    repeat (8) cyc(1'b1, 8'h01);
    cyc(1'b1, 8'hF0);
    chk("mid_stall", 64'(stall), 64'd1);
    chk("mid_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    chk("arst_off", 64'(out_offset), 64'd0);
    chk("arst_id", 64'(out_id), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sc = '0;
    out_ready = 1'b1;
    repeat (6) cyc(1'b0, 8'h00);
    chk("arst_no_stale", 64'(out_valid), 64'd0);

    // flush mid-drain
    out_ready = 1'b0;
    repeat (8) cyc(1'b1, 8'h01);
    cyc(1'b1, 8'hF0);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    chk("pre_flush_stall", 64'(stall), 64'd1);
    flush_cyc();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_stall", 64'(stall), 64'd0);
    chk("flush_off", 64'(out_offset), 64'd0);
    chk("flush_id", 64'(out_id), 64'd0);
    out_ready = 1'b1;
    repeat (6) cyc(1'b0, 8'h00);
    chk("flush_no_stale", 64'(out_valid), 64'd0);
    chk("end_q1", 64'(q1.size()), 64'd0);
    chk("end_q2", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
